// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : snake_pkg                                              |
// | Description : Shared direction and controller state encodings for    |
// |               the snake game controller and engine.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package snake_pkg;

  // Committed / queued direction encoding
  localparam logic [2:0] C_DIR_NONE  = 3'd0;
  localparam logic [2:0] C_DIR_UP    = 3'd1;
  localparam logic [2:0] C_DIR_DOWN  = 3'd2;
  localparam logic [2:0] C_DIR_LEFT  = 3'd3;
  localparam logic [2:0] C_DIR_RIGHT = 3'd4;

  // Controller FSM encoding, exported on the state port
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Reverse of a direction; NONE has no opposite
  function automatic logic [2:0] dir_opposite(input logic [2:0] d);
    logic [2:0] o;
    case (d)
      C_DIR_UP:    o = C_DIR_DOWN;
      C_DIR_DOWN:  o = C_DIR_UP;
      C_DIR_LEFT:  o = C_DIR_RIGHT;
      C_DIR_RIGHT: o = C_DIR_LEFT;
      default:     o = C_DIR_NONE;
    endcase
    return o;
  endfunction

  // Step period in speed units, evaluated signed so a high score
  // cannot wrap below the floor
  function automatic int step_period(input int base, input int step,
                                     input int floor_p, input logic [3:0] score);
    int p;
    p = base - int'({28'd0, score}) * step;
    if (p < floor_p) p = floor_p;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : snake_dir_queue                                        |
// | Description : Two-entry direction FIFO with press filtering against  |
// |               the tail entry (or committed direction when empty).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       accept,
  input  logic       ev_up,
  input  logic       ev_down,
  input  logic       ev_left,
  input  logic       ev_right,
  input  logic [2:0] cur_dir,
  input  logic       pop,
  output logic [2:0] head,
  output logic       valid
);

  logic [2:0] slot0_q, slot0_d;
  logic [2:0] slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic [2:0] cand;
  logic [2:0] ref_dir;
  logic       reject;
  logic       do_pop;
  logic       do_push;

  assign head  = slot0_q;
  assign valid = (count_q != 2'd0);

  // Candidate selection, filtering and FIFO next-state
  always_comb begin
    cand = C_DIR_NONE;
    if      (ev_up)    cand = C_DIR_UP;
    else if (ev_down)  cand = C_DIR_DOWN;
    else if (ev_left)  cand = C_DIR_LEFT;
    else if (ev_right) cand = C_DIR_RIGHT;

    case (count_q)
      2'd0:    ref_dir = cur_dir;
      2'd1:    ref_dir = slot0_q;
      default: ref_dir = slot1_q;
    endcase

    reject = (cand == C_DIR_NONE) || (cand == ref_dir) ||
             ((ref_dir != C_DIR_NONE) && (cand == dir_opposite(ref_dir)));

    do_pop  = pop && valid;
    // A pop in the same cycle frees the slot the push needs
    do_push = accept && !reject && ((count_q != 2'd2) || do_pop);

    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = cand;
        else                 slot1_d = cand;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = cand;
        end else begin
          slot0_d = slot1_q;
          slot1_d = cand;
        end
      end
      default: ;
    endcase

    if (flush) count_d = 2'd0;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot0_q <= C_DIR_NONE;
      slot1_q <= C_DIR_NONE;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : snake_game_ctrl                                        |
// | Description : Snake game controller: button edge detection, step     |
// |               timing with score-based speed-up, engine handshake,    |
// |               pause and game-over handling.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int PRESCALE    = 50000,
  parameter int BASE_PERIOD = 16,
  parameter int SPEED_STEP  = 1,
  parameter int MIN_PERIOD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic [3:0] score,
  input  logic       step_ack,
  input  logic       dead,
  output logic       step_req,
  output logic [2:0] dir,
  output logic       clear_game,
  output logic [2:0] state,
  output logic       game_over
);

  localparam int PRE_W    = $clog2(PRESCALE);
  localparam int UNIT_MAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
  localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(PRESCALE - 1);

  state_e            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [2:0]        dir_q, dir_d;
  logic              pend_q, pend_d;
  logic              clear_q, clear_d;
  logic [4:0]        btn_q;

  logic [4:0]        btn_now;
  logic [4:0]        btn_ev;
  logic              start_ev;
  logic [UNIT_W-1:0] unit_inc;
  logic [UNIT_W-1:0] period_units;
  logic              q_pop;
  logic              q_flush;
  logic              q_accept;
  logic [2:0]        q_head;
  logic              q_valid;

  // Buttons are active-low: an event is released-last-cycle, pressed-now
  assign btn_now  = {start, up, down, left, right};
  assign btn_ev   = btn_q & ~btn_now;
  assign start_ev = btn_ev[4];

  assign unit_inc     = unit_q + UNIT_W'(1);
  assign period_units = UNIT_W'(step_period(BASE_PERIOD, SPEED_STEP, MIN_PERIOD, score));

  assign q_accept = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_PAUSE);

  assign step_req   = (state_q == ST_STEP);
  assign dir        = dir_q;
  assign clear_game = clear_q;
  assign state      = state_q;
  assign game_over  = (state_q == ST_OVER);

  snake_dir_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (q_flush),
    .accept   (q_accept),
    .ev_up    (btn_ev[3]),
    .ev_down  (btn_ev[2]),
    .ev_left  (btn_ev[1]),
    .ev_right (btn_ev[0]),
    .cur_dir  (dir_q),
    .pop      (q_pop),
    .head     (q_head),
    .valid    (q_valid)
  );

  // Next-state, step timer and direction commit
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    unit_d  = unit_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    clear_d = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        q_flush = 1'b1;
        pre_d   = '0;
        unit_d  = '0;
        dir_d   = C_DIR_NONE;
        pend_d  = 1'b0;
        if (start_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev) begin
          state_d = ST_PAUSE;
        end else if (pre_q == C_PRE_LAST) begin
          pre_d = '0;
          // >= so a score jump that shrinks the period mid-count still steps
          if (unit_inc >= period_units) begin
            unit_d  = '0;
            state_d = ST_STEP;
            if (q_valid) begin
              q_pop = 1'b1;
              dir_d = q_head;
            end
          end else begin
            unit_d = unit_inc;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_STEP: begin
        if (step_ack) begin
          pend_d = 1'b0;
          if (dead)                      state_d = ST_OVER;
          else if (pend_q || start_ev)   state_d = ST_PAUSE;
          else                           state_d = ST_RUN;
        end else if (start_ev) begin
          pend_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_ev) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (start_ev) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      unit_q  <= '0;
      dir_q   <= C_DIR_NONE;
      pend_q  <= 1'b0;
      clear_q <= 1'b0;
      btn_q   <= 5'b11111;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      clear_q <= clear_d;
      btn_q   <= btn_now;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_snake_game_ctrl                                     |
// | Description : Directed self-checking bench for snake_game_ctrl.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1, start = 1'b1;
  logic [3:0] score = 4'd14;
  logic       step_ack = 1'b0;
  logic       dead = 1'b0;
  logic       step_req;
  logic [2:0] dir;
  logic       clear_game;
  logic [2:0] state;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  snake_game_ctrl #(
    .PRESCALE    (2),
    .BASE_PERIOD (16),
    .SPEED_STEP  (1),
    .MIN_PERIOD  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .start      (start),
    .score      (score),
    .step_ack   (step_ack),
    .dead       (dead),
    .step_req   (step_req),
    .dir        (dir),
    .clear_game (clear_game),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle press then release (0=up,1=down,2=left,3=right,4=start)
  task automatic press(input int b);
    case (b)
      0: up = 1'b0;
      1: down = 1'b0;
      2: left = 1'b0;
      3: right = 1'b0;
      default: start = 1'b0;
    endcase
    tick();
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1; start = 1'b1;
  endtask

  // Wait (bounded) for step_req; exp_n < 0 skips the latency check
  task automatic wait_step(input string tag, input int exp_n);
    int n;
    n = 0;
    while (step_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, step_req}, 32'd1);
    if (exp_n >= 0) chk({tag, "_lat"}, n, exp_n);
  endtask

  task automatic do_ack(input string tag, input logic [2:0] exp_state);
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
    chk({tag, "_reqlow"}, {31'd0, step_req}, 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_req", {31'd0, step_req}, 32'd0);
    chk("rst_dir", {29'd0, dir}, 32'd0);
    chk("rst_clear", {31'd0, clear_game}, 32'd0);
    chk("rst_over", {31'd0, game_over}, 32'd0);

    // Direction press in IDLE is ignored; start enters RUN
    press(0); tick();
    press(4);
    chk("idle_to_run", {29'd0, state}, 32'd1);
    wait_step("first", 8);
    chk("first_dir", {29'd0, dir}, 32'd0);
    tick(); tick();
    chk("step_hold_req", {31'd0, step_req}, 32'd1);
    chk("step_hold_state", {29'd0, state}, 32'd2);
    do_ack("ack1", 3'd1);

    // Stray ack in RUN ignored
    step_ack = 1'b1; tick(); step_ack = 1'b0;
    chk("stray_ack", {29'd0, state}, 32'd1);

    // Up+right together -> only UP; then LEFT queued; DOWN dropped (full)
    up = 1'b0; right = 1'b0; tick();
    up = 1'b1; right = 1'b1; tick();
    press(2); tick();
    press(1);
    wait_step("q1", -1);
    chk("q1_dir", {29'd0, dir}, 32'd1);
    do_ack("ack2", 3'd1);
    wait_step("q2", -1);
    chk("q2_dir", {29'd0, dir}, 32'd3);
    do_ack("ack3", 3'd1);
    wait_step("q3", -1);
    chk("q3_dir", {29'd0, dir}, 32'd3);
    do_ack("ack4", 3'd1);

    // Get to UP, then opposite (down) dropped and LEFT taken
    press(0);
    wait_step("to_up", -1);
    chk("to_up_dir", {29'd0, dir}, 32'd1);
    do_ack("ack5", 3'd1);
    press(1); tick();
    press(2);
    wait_step("opp", -1);
    chk("opp_dir", {29'd0, dir}, 32'd3);
    do_ack("ack6", 3'd1);

    // Equal direction dropped, next valid press taken
    press(2); tick();
    press(0);
    wait_step("eq", -1);
    chk("eq_dir", {29'd0, dir}, 32'd1);

    // Period: score 2 -> 14 units, score 12 -> 4 units
    score = 4'd2;
    do_ack("ack7", 3'd1);
    wait_step("per14", 28);
    score = 4'd12;
    do_ack("ack8", 3'd1);
    wait_step("per4", 8);
    score = 4'd14;
    do_ack("ack9", 3'd1);

    // Pause in RUN holds counters
    tick(); tick();
    press(4);
    chk("pause_enter", {29'd0, state}, 32'd3);
    repeat (10) tick();
    chk("pause_hold", {29'd0, state}, 32'd3);
    chk("pause_noreq", {31'd0, step_req}, 32'd0);
    press(4);
    chk("pause_resume", {29'd0, state}, 32'd1);
    wait_step("resume", 6);

    // Start during STEP is deferred to the ack
    press(4);
    chk("pend_step", {29'd0, state}, 32'd2);
    do_ack("pend_ack", 3'd3);
    press(4);
    chk("pend_run", {29'd0, state}, 32'd1);

    // Dead without ack ignored; dead with ack ends the game
    wait_step("dead", -1);
    dead = 1'b1; tick(); dead = 1'b0;
    chk("dead_noack", {29'd0, state}, 32'd2);
    dead = 1'b1;
    do_ack("dead_ack", 3'd4);
    dead = 1'b0;
    chk("over_flag", {31'd0, game_over}, 32'd1);
    chk("over_noclear", {31'd0, clear_game}, 32'd0);
    press(4);
    chk("over_idle", {29'd0, state}, 32'd0);
    chk("clear_hi", {31'd0, clear_game}, 32'd1);
    tick();
    chk("clear_lo", {31'd0, clear_game}, 32'd0);
    chk("over_lo", {31'd0, game_over}, 32'd0);
    chk("idle_dir", {29'd0, dir}, 32'd0);

    // Reset in the middle of a handshake
    press(4);
    press(3);
    wait_step("rst_mid", -1);
    chk("rst_mid_dir", {29'd0, dir}, 32'd4);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst_mid_req", {31'd0, step_req}, 32'd0);
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    chk("rst_mid_dir0", {29'd0, dir}, 32'd0);
    step_ack = 1'b1; tick(); step_ack = 1'b0;
    chk("late_ack_state", {29'd0, state}, 32'd0);
    chk("late_ack_req", {31'd0, step_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000, clock cycles per speed unit (>=2).
REQ-002 Parameter BASE_PERIOD, default 16, speed units between steps at score 0.
REQ-003 Parameter SPEED_STEP, default 1, speed units removed per score point.
REQ-004 Parameter MIN_PERIOD, default 4, floor on step period in speed units (>=1).
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 up, down, left, right  in  1 each  synchronized, debounced buttons, active-low (pressed = 0).
REQ-008 start  in  1  synchronized, debounced start/pause button, active-low.
REQ-009 score  in  4  current engine score.
REQ-010 step_ack  in  1  one-cycle engine acknowledge that a step completed.
REQ-011 dead  in  1  engine death flag; sampled only in the step_ack cycle.
REQ-012 step_req  out  1  step request to engine, level handshake.
REQ-013 dir  out  3  committed direction: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4.
REQ-014 clear_game  out  1  one-cycle engine/score clear pulse.
REQ-015 state  out  3  current FSM state encoding.
REQ-016 game_over  out  1  high while in OVER.

Function
REQ-017 Press event = 1->0 transition on a button between consecutive cycles; holding generates no further events.
REQ-018 FSM states: IDLE, RUN, STEP, PAUSE, OVER.
REQ-019 IDLE: start event -> RUN; timer cleared, dir = NONE, queue empty.
REQ-020 RUN: prescaler counts 0..PRESCALE-1; at wrap the unit counter increments; when unit counter reaches period, -> STEP, both counters cleared.
REQ-021 period = max(BASE_PERIOD - score*SPEED_STEP, MIN_PERIOD), computed signed, sampled on each RUN->STEP transition.
REQ-022 Entering STEP: if queue non-empty, pop head into dir in the same cycle step_req rises; else dir unchanged.
REQ-023 step_req high throughout STEP; dir stable while step_req high.
REQ-024 STEP + step_ack: step_req low next cycle; dead=1 -> OVER, else pause pending -> PAUSE, else -> RUN.
REQ-025 Start event in RUN -> PAUSE; in STEP sets pause pending, honoured at step_ack.
REQ-026 PAUSE: counters hold; start event -> RUN resuming from held counts.
REQ-027 OVER: game_over=1; start event -> IDLE with clear_game=1 for exactly that transition cycle.
REQ-028 Direction queue: 2-entry FIFO, accepting events in RUN, STEP and PAUSE; events ignored in IDLE and OVER.
REQ-029 Simultaneous events: only one enqueued per cycle, priority up > down > left > right.
REQ-030 Reference = queue tail if non-empty, else dir; event dropped if equal to or opposite of reference (opposite rejection skipped when reference is NONE).
REQ-031 Queue full: new event dropped; pop and push in same cycle both occur.
REQ-032 step_ack outside STEP ignored; dead outside step_ack cycle ignored.
REQ-033 Direction and start events in the same cycle both processed.

Reset
REQ-034 rst=0 at a posedge: state=IDLE, step_req=0, dir=NONE, clear_game=0, game_over=0, queue empty, counters 0, pause pending 0, edge-detect history = released (1); applies in any state, including mid-handshake.

Structure
REQ-035 Shared package snake_pkg holds dir encoding constants and FSM state encoding, also used by the engine.
REQ-036 Sub-module snake_dir_queue implements REQ-028..031; rest in snake_game_ctrl.

Verification
REQ-037 PRESCALE=2, BASE_PERIOD=4, score=0: start press -> first step_req rises 8 cycles after RUN entry; ack -> RUN, repeat.
REQ-038 score=14, SPEED_STEP=1, MIN_PERIOD=4 -> period clamps at 4 units; score=2 -> 14 units.
REQ-039 dir=UP, press down then left in RUN -> down dropped, LEFT enqueued, dir=LEFT at next step_req.
REQ-040 Up and right pressed same cycle, dir=NONE -> only UP enqueued; three distinct valid presses -> third dropped.
REQ-041 step_ack with dead=1 -> OVER, game_over=1; start press -> IDLE, clear_game high one cycle.
REQ-042 rst=0 during STEP with step_req=1 -> next cycle step_req=0, state=IDLE, dir=NONE; late step_ack ignored.
